accum_regfile_datapath: RTL

Parametrised accumulator datapath with a register file. It generalises the fixed two-register plus accumulator mux/adder datapath to NUM_REGS registers and a DATA_WIDTH-bit accumulator. It adds an opcode-driven control FSM with a valid/ready handshake, a multi-cycle SUMALL operation, and carry/zero flags. It sits between the lab control logic, which issues opcodes, and the display/readback logic, which samples acc_o and rd_data.

---
 rtl/accum_regfile_datapath.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/accum_regfile_datapath.sv
// Accumulator datapath with NUM_REGS-entry register file, opcode FSM,
// valid/ready handshake, multi-cycle SUMALL and carry/zero flags.
//
// Ports:
//   Clk, reset        clock, async active-high reset
//   reset_value       value loaded into every register and acc on reset
//   op_valid/op_ready opcode handshake (accept on valid && ready)
//   opcode            3-bit operation
//   src_sel, dst_sel  source / destination register selects
//   imm               immediate for LOADI
//   rd_sel, rd_data   combinational register readback
//   acc_o             accumulator
//   carry_o, zero_o   carry flag, acc == 0
//   done              one-cycle pulse after SUMALL completes
module accum_regfile_datapath #(
   parameter  int DATA_WIDTH = 8,
   parameter  int NUM_REGS   = 4,
   localparam int SEL_WIDTH  = $clog2(NUM_REGS)
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] reset_value,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [2:0]            opcode,
   input  logic [SEL_WIDTH-1:0]  src_sel,
   input  logic [SEL_WIDTH-1:0]  dst_sel,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [SEL_WIDTH-1:0]  rd_sel,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] acc_o,
   output logic                  carry_o,
   output logic                  zero_o,
   output logic                  done
);

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_STORE  = 3'b011;
   localparam logic [2:0] OP_MOVE   = 3'b100;
   localparam logic [2:0] OP_LOADI  = 3'b101;
   localparam logic [2:0] OP_SUMALL = 3'b110;
   localparam logic [2:0] OP_CLEAR  = 3'b111;

   typedef enum logic {IDLE, SUM} state_t;

   state_t                  state;
   state_t                  next_state;
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
   logic [DATA_WIDTH-1:0]   acc;
   logic                    carry;
   logic [SEL_WIDTH-1:0]    idx;
   logic                    accept;
   logic                    last;
   logic [DATA_WIDTH-1:0]   src_val;
   logic [DATA_WIDTH-1:0]   idx_val;
   logic [DATA_WIDTH-1:0]   addend;
   logic [DATA_WIDTH:0]     sum;
   logic                    wr_en;
   logic [DATA_WIDTH-1:0]   wr_data;

   assign op_ready = (state == IDLE) && !reset;
   assign accept   = op_valid && op_ready;
   assign last     = (idx == SEL_WIDTH'(NUM_REGS - 1));
   assign acc_o    = acc;
   assign carry_o  = carry;
   assign zero_o   = (acc == '0);

   // Select-matching muxes: an unmatched (out of range) select reads 0.
   always_comb begin
      src_val = '0;
      idx_val = '0;
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (src_sel == SEL_WIDTH'(i)) src_val = regs[i];
         if (idx == SEL_WIDTH'(i))     idx_val = regs[i];
         if (rd_sel == SEL_WIDTH'(i))  rd_data = regs[i];
      end
   end

   // One shared adder: SUM walks the file, IDLE SUMALL starts at R[0].
   always_comb begin
      if (state == SUM)
         addend = idx_val;
      else if (opcode == OP_SUMALL)
         addend = regs[0];
      else
         addend = src_val;
      sum = {1'b0, acc} + {1'b0, addend};
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_data = '0;
      if (accept) begin
         case (opcode)
            OP_STORE: begin wr_en = 1'b1; wr_data = acc;     end
            OP_MOVE:  begin wr_en = 1'b1; wr_data = src_val; end
            OP_LOADI: begin wr_en = 1'b1; wr_data = imm;     end
            default:  ;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept && opcode == OP_SUMALL) next_state = SUM;
         SUM:  if (last) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Writes with an unmatched dst_sel fall through and are dropped.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= reset_value;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (dst_sel == SEL_WIDTH'(i)) regs[i] <= wr_data;
      end
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         acc   <= reset_value;
         carry <= 1'b0;
         idx   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == SUM) begin
            acc   <= sum[DATA_WIDTH-1:0];
            carry <= carry | sum[DATA_WIDTH];
            idx   <= last ? '0 : idx + 1'b1;
            done  <= last;
         end else if (accept) begin
            case (opcode)
               OP_LOAD: acc <= src_val;
               OP_ADD: begin
                  acc   <= sum[DATA_WIDTH-1:0];
                  carry <= sum[DATA_WIDTH];
               end
               OP_SUMALL: begin
                  acc   <= sum[DATA_WIDTH-1:0];
                  carry <= sum[DATA_WIDTH];
                  idx   <= SEL_WIDTH'(1);
               end
               OP_CLEAR: begin
                  acc   <= '0;
                  carry <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
